// File: rtl/pwm_meas_pkg.sv
// Shared types and constants for the PWM duty-cycle meter.
package pwm_meas_pkg;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } meas_state_e;

    localparam int DEF_CNT_W  = 12;
    localparam int DEF_DUTY_W = 10;

    // Width of the divider numerator high * 2^duty_w.
    function automatic int num_width(input int cnt_w, input int duty_w);
        return cnt_w + duty_w;
    endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider: quo = floor(num / den), one quotient bit per clock.
// The numerator's upper CNT_W bits must be smaller than den, which holds
// because the high time is always shorter than the period; the quotient
// therefore fits in DUTY_W bits and only DUTY_W iterations are needed.
module pwm_duty_div
    import pwm_meas_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DUTY_W = DEF_DUTY_W
) (
    input  logic                                   clk,
    input  logic                                   rstb,
    input  logic                                   start,
    input  logic [num_width(CNT_W, DUTY_W)-1:0]    num,
    input  logic [CNT_W-1:0]                       den,
    output logic                                   busy,
    output logic                                   done,
    output logic [DUTY_W-1:0]                      quo
);

    localparam int NUM_W  = num_width(CNT_W, DUTY_W);
    localparam int STEP_W = $clog2(DUTY_W + 1);

    logic [CNT_W:0]      rem_r;
    logic [DUTY_W-1:0]   lo_r;
    logic [CNT_W-1:0]    den_r;
    logic [DUTY_W-1:0]   quo_r;
    logic [STEP_W-1:0]   step_r;
    logic                busy_r;
    logic                done_r;
    logic [CNT_W:0]      rem_sh_s;
    logic [CNT_W:0]      rem_sub_s;
    logic                ge_s;

    // Trial subtraction for the current quotient bit.
    always_comb begin
        rem_sh_s  = {rem_r[CNT_W-1:0], lo_r[DUTY_W-1]};
        rem_sub_s = rem_sh_s - {1'b0, den_r};
        ge_s      = (rem_sh_s >= {1'b0, den_r});
    end

    // Iteration state: load on start, then shift/subtract DUTY_W times.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rem_r  <= '0;
            lo_r   <= '0;
            den_r  <= '0;
            quo_r  <= '0;
            step_r <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                rem_r  <= {1'b0, num[NUM_W-1:DUTY_W]};
                lo_r   <= num[DUTY_W-1:0];
                den_r  <= den;
                quo_r  <= '0;
                step_r <= STEP_W'(DUTY_W);
                busy_r <= 1'b1;
            end else if (busy_r) begin
                rem_r  <= ge_s ? rem_sub_s : rem_sh_s;
                lo_r   <= {lo_r[DUTY_W-2:0], 1'b0};
                quo_r  <= {quo_r[DUTY_W-2:0], ge_s};
                step_r <= step_r - STEP_W'(1);
                if (step_r == STEP_W'(1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    busy_r <= 1'b1;
                end
            end else begin
                busy_r <= 1'b0;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign quo  = quo_r;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty-cycle meter: synchronizes pwm_in, measures high time and period
// of each complete rise-to-rise cycle and divides them into a duty code.
// Optional glitch filter enabled by defining PWM_GLITCH_FILT_EN.
module pwm_duty_meter
    import pwm_meas_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DUTY_W  = DEF_DUTY_W,
    parameter int TIMEOUT = 4095,
    parameter int FILT_N  = 3
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_code,
    output logic [CNT_W-1:0]  high_cnt,
    output logic [CNT_W-1:0]  period_cnt,
    output logic              valid,
    output logic              timeout,
    output logic              stuck_lvl,
    output logic              ovr
);

    localparam int NUM_W  = num_width(CNT_W, DUTY_W);
    // Rises are ignored until the input pipeline holds real samples, so a
    // high level present at reset release is not mistaken for an edge.
    localparam int WARM_N = 2 + FILT_N;
    localparam int WARM_W = $clog2(WARM_N + 1);

    logic              sync1_r, sync2_r;
    logic              lvl_s, lvl_q_r;
    logic              rise_s, fall_s;
    logic [WARM_W-1:0] warm_r;
    logic              armed_s;
    meas_state_e       state_r;
    logic [CNT_W-1:0]  p_cnt_r, h_cnt_r;
    logic [CNT_W-1:0]  pend_h_r, pend_p_r;
    logic              timeout_r, stuck_lvl_r, ovr_r;
    logic [DUTY_W-1:0] duty_r;
    logic [CNT_W-1:0]  high_r, period_r;
    logic              valid_r;
    logic              start_s;
    logic              div_busy_s, div_done_s;
    logic [DUTY_W-1:0] div_quo_s;
    logic [NUM_W-1:0]  div_num_s;

    // Two-flop synchronizer for the asynchronous PWM input.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pwm_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef PWM_GLITCH_FILT_EN
    localparam int FC_W = ($clog2(FILT_N) < 1) ? 1 : $clog2(FILT_N);
    logic [FC_W-1:0] filt_cnt_r;
    logic            flip_s;

    // Level flips on the FILT_N-th consecutive differing sample.
    always_comb begin
        flip_s = (sync2_r != lvl_q_r) && (filt_cnt_r == FC_W'(FILT_N - 1));
        if (flip_s) begin
            lvl_s = sync2_r;
        end else begin
            lvl_s = lvl_q_r;
        end
    end

    // Count consecutive samples that disagree with the filtered level.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            filt_cnt_r <= '0;
        end else if ((sync2_r != lvl_q_r) && !flip_s) begin
            filt_cnt_r <= filt_cnt_r + FC_W'(1);
        end else begin
            filt_cnt_r <= '0;
        end
    end
`else
    // Without the filter the synchronized sample is the level directly.
    always_comb begin
        lvl_s = sync2_r;
    end
`endif

    // Previous level for edge detection; also the filter's held level.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            lvl_q_r <= 1'b0;
        end else begin
            lvl_q_r <= lvl_s;
        end
    end

    assign rise_s = lvl_s & ~lvl_q_r;
    assign fall_s = ~lvl_s & lvl_q_r;

    // Warm-up counter covering the synchronizer and filter depth.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            warm_r <= '0;
        end else if (warm_r != WARM_W'(WARM_N)) begin
            warm_r <= warm_r + WARM_W'(1);
        end else begin
            warm_r <= warm_r;
        end
    end

    assign armed_s = (warm_r == WARM_W'(WARM_N));

    // A completed period goes to the divider only if it is free.
    always_comb begin
        start_s   = (state_r == LOW) && rise_s && !div_busy_s;
        div_num_s = {h_cnt_r, {DUTY_W{1'b0}}};
    end

    // Measurement FSM with sticky timeout/overrun status.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r     <= IDLE;
            p_cnt_r     <= '0;
            h_cnt_r     <= '0;
            pend_h_r    <= '0;
            pend_p_r    <= '0;
            timeout_r   <= 1'b0;
            stuck_lvl_r <= 1'b0;
            ovr_r       <= 1'b0;
        end else begin
            if (div_done_s) begin
                timeout_r <= 1'b0;
                ovr_r     <= 1'b0;
            end else begin
                timeout_r <= timeout_r;
                ovr_r     <= ovr_r;
            end
            case (state_r)
                IDLE: begin
                    if (rise_s && armed_s) begin
                        state_r <= HIGH;
                        p_cnt_r <= CNT_W'(1);
                        h_cnt_r <= CNT_W'(1);
                    end else begin
                        p_cnt_r <= '0;
                        h_cnt_r <= '0;
                    end
                end
                HIGH: begin
                    if (p_cnt_r == CNT_W'(TIMEOUT)) begin
                        state_r     <= IDLE;
                        p_cnt_r     <= '0;
                        h_cnt_r     <= '0;
                        timeout_r   <= 1'b1;
                        stuck_lvl_r <= lvl_s;
                    end else if (fall_s) begin
                        state_r <= LOW;
                        p_cnt_r <= p_cnt_r + CNT_W'(1);
                    end else begin
                        p_cnt_r <= p_cnt_r + CNT_W'(1);
                        h_cnt_r <= h_cnt_r + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (rise_s) begin
                        state_r <= HIGH;
                        p_cnt_r <= CNT_W'(1);
                        h_cnt_r <= CNT_W'(1);
                        if (div_busy_s) begin
                            ovr_r <= 1'b1;
                        end else begin
                            pend_h_r <= h_cnt_r;
                            pend_p_r <= p_cnt_r;
                        end
                    end else if (p_cnt_r == CNT_W'(TIMEOUT)) begin
                        state_r     <= IDLE;
                        p_cnt_r     <= '0;
                        h_cnt_r     <= '0;
                        timeout_r   <= 1'b1;
                        stuck_lvl_r <= lvl_s;
                    end else begin
                        p_cnt_r <= p_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    p_cnt_r <= '0;
                    h_cnt_r <= '0;
                end
            endcase
        end
    end

    pwm_duty_div #(
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W)
    ) u_div (
        .clk   (clk),
        .rstb  (rstb),
        .start (start_s),
        .num   (div_num_s),
        .den   (p_cnt_r),
        .busy  (div_busy_s),
        .done  (div_done_s),
        .quo   (div_quo_s)
    );

    // Result registers: all measurement outputs update together with valid.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            duty_r   <= '0;
            high_r   <= '0;
            period_r <= '0;
            valid_r  <= 1'b0;
        end else if (div_done_s) begin
            duty_r   <= div_quo_s;
            high_r   <= pend_h_r;
            period_r <= pend_p_r;
            valid_r  <= 1'b1;
        end else begin
            valid_r  <= 1'b0;
        end
    end

    assign duty_code  = duty_r;
    assign high_cnt   = high_r;
    assign period_cnt = period_r;
    assign valid      = valid_r;
    assign timeout    = timeout_r;
    assign stuck_lvl  = stuck_lvl_r;
    assign ovr        = ovr_r;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter: a rise-to-rise model of the PWM
// waveform predicts every result; a per-cycle monitor checks the outputs.
module tb_pwm_duty_meter;

    localparam int CNT_W   = 12;
    localparam int DUTY_W  = 10;
    localparam int TIMEOUT = 4095;
    localparam int FILT_N  = 3;

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic              pwm_in = 1'b0;
    logic [DUTY_W-1:0] duty_code;
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  period_cnt;
    logic              valid;
    logic              timeout;
    logic              stuck_lvl;
    logic              ovr;

    pwm_duty_meter #(
        .CNT_W(CNT_W), .DUTY_W(DUTY_W), .TIMEOUT(TIMEOUT), .FILT_N(FILT_N)
    ) dut (
        .clk(clk), .rstb(rstb), .pwm_in(pwm_in),
        .duty_code(duty_code), .high_cnt(high_cnt), .period_cnt(period_cnt),
        .valid(valid), .timeout(timeout), .stuck_lvl(stuck_lvl), .ovr(ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int h;
        int p;
    } res_t;

    res_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   n_valid = 0;
    bit   ovr_seen = 1'b0;

    // Model state: times are in clock cycles of the driven waveform.
    logic mdl_lvl = 1'b0;
    bit   have_rise = 1'b0;
    int   last_rise = 0;
    int   last_fall = 0;
    bit   acc_valid = 1'b0;
    int   last_acc = 0;

    int   last_duty = 0;
    int   last_h = 0;
    int   last_p = 0;

    function automatic int duty_of(input int h, input int p);
        return (h * (1 << DUTY_W)) / p;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // A rising edge closes the previous period; it yields a result unless it
    // was longer than TIMEOUT or the divider is still busy with the last one.
    task automatic model_rise(input int t);
        res_t r;
        if (have_rise && (t - last_rise) <= TIMEOUT) begin
            if (!acc_valid || (t - last_acc) >= DUTY_W + 2) begin
                r.p = t - last_rise;
                r.h = last_fall - last_rise;
                r.duty = duty_of(r.h, r.p);
                exp_q.push_back(r);
                acc_valid = 1'b1;
                last_acc = t;
            end
        end
        have_rise = 1'b1;
        last_rise = t;
    endtask

    task automatic model_reset();
        have_rise = 1'b0;
        acc_valid = 1'b0;
        exp_q.delete();
        mdl_lvl = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Drive a level for n cycles; vis=0 hides the change from the model.
    task automatic seg(input logic lvl, input int n, input bit vis);
        if (vis && lvl != mdl_lvl) begin
            if (lvl) model_rise(cyc);
            else last_fall = cyc;
            mdl_lvl = lvl;
        end
        pwm_in = lvl;
        tick(n);
    endtask

    task automatic pair(input int h, input int p);
        seg(1'b1, h, 1'b1);
        seg(1'b0, p - h, 1'b1);
    endtask

    // Per-cycle monitor: zeros in reset, model results on valid, hold otherwise.
    always @(negedge clk) begin
        res_t e;
        if (!rstb) begin
            chk("reset_outputs", {duty_code, high_cnt, period_cnt, valid, timeout, stuck_lvl, ovr}, 0);
            last_duty = 0;
            last_h = 0;
            last_p = 0;
        end else if (valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_valid: got valid=1 duty=%0d, expected no result (cycle %0d)", duty_code, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("duty_code", duty_code, e.duty);
                chk("high_cnt", high_cnt, e.h);
                chk("period_cnt", period_cnt, e.p);
                chk("timeout_clr", timeout, 0);
                chk("ovr_clr", ovr, 0);
                last_duty = e.duty;
                last_h = e.h;
                last_p = e.p;
            end
        end else begin
            chk("hold_duty", duty_code, last_duty);
            chk("hold_high", high_cnt, last_h);
            chk("hold_period", period_cnt, last_p);
        end
        if (rstb && ovr) ovr_seen = 1'b1;
    end

    int sweep[8] = '{50, 309, 588, 809, 900, 900, 707, 383};
    int v0;

    initial begin
        // Pin the model arithmetic with hand-computed codes.
        chk("model_50pct", duty_of(500, 1000), 512);
        chk("model_5pct", duty_of(50, 1000), 51);
        chk("model_90pct", duty_of(900, 1000), 921);

        rstb = 1'b0;
        pwm_in = 1'b0;
        tick(5);
        rstb = 1'b1;
        seg(1'b0, 20, 1'b1);

        // 50 % duty at 1000-cycle period: first full period gives no result.
        repeat (4) pair(500, 1000);
        chk("p50_duty", duty_code, 512);
        chk("p50_high", high_cnt, 500);
        chk("p50_period", period_cnt, 1000);
        chk("p50_valid_count", n_valid, 3);

        repeat (3) pair(50, 1000);
        chk("p5_duty", duty_code, 51);
        repeat (3) pair(900, 1000);
        chk("p90_duty", duty_code, 921);

        foreach (sweep[i]) pair(sweep[i], 1000);

        // Stuck high: no timeout before TIMEOUT cycles, then sticky timeout.
        seg(1'b1, 4000, 1'b1);
        chk("stuck_early_timeout", timeout, 0);
        seg(1'b1, 1000, 1'b1);
        chk("stuck_timeout", timeout, 1);
        chk("stuck_lvl", stuck_lvl, 1);
        seg(1'b0, 500, 1'b1);
        repeat (3) pair(500, 1000);
        chk("restore_timeout", timeout, 0);
        chk("restore_duty", duty_code, 512);

        // Short period below the divider latency: alternate drops.
        ovr_seen = 1'b0;
        repeat (10) pair(4, 8);
        chk("short_ovr_seen", ovr_seen, 1);
        repeat (3) pair(500, 1000);
        chk("return_ovr", ovr, 0);
        chk("return_duty", duty_code, 512);

        // One-cycle low glitch in the middle of the high phase.
        seg(1'b1, 250, 1'b1);
`ifdef PWM_GLITCH_FILT_EN
        seg(1'b0, 1, 1'b0);
`else
        seg(1'b0, 1, 1'b1);
`endif
        seg(1'b1, 249, 1'b1);
        seg(1'b0, 500, 1'b1);
        repeat (2) pair(500, 1000);
        chk("glitch_after_duty", duty_code, 512);

        // Reset while the divider is working on a fresh period.
        seg(1'b1, 6, 1'b1);
        rstb = 1'b0;
        #1;
        chk("async_reset_outputs", {duty_code, high_cnt, period_cnt, valid, timeout, stuck_lvl, ovr}, 0);
        model_reset();
        pwm_in = 1'b0;
        tick(5);
        rstb = 1'b1;
        seg(1'b0, 20, 1'b1);
        v0 = n_valid;
        repeat (3) pair(500, 1000);
        chk("post_reset_valid_count", n_valid - v0, 2);
        seg(1'b0, 50, 1'b1);
        chk("pending_results", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
